// File: rtl/alu_result_writeback.sv
// Post-ALU result stage: captures the ALU result, runs the data-memory access for
// loads/stores, and routes the final value to the register file or the PC.
module alu_result_writeback #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              ALU_Zero,
  input  logic              C_Start,
  input  logic [1:0]        C_Op,
  input  logic [REG_AW-1:0] C_RegDst,
  input  logic [DATA_W-1:0] C_StoreData,
  input  logic              C_PCWrite,
  input  logic              C_PCWriteCond,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              RegWrite_En,
  output logic [REG_AW-1:0] RegWrite_Addr,
  output logic [DATA_W-1:0] RegWrite_Data,
  output logic [DATA_W-1:0] PC_Out,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {IDLE, MEM, WB, PCUPD, FIN} state_t;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t            state;
  logic [DATA_W-1:0] alu_out_reg;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] dst_reg;
  logic [1:0]        op_reg;
  logic              zero_reg;
  logic              pc_write_reg;
  logic              pc_write_cond_reg;

  // Address/data views come straight from the latched operands, so they stay
  // stable for the whole memory request without extra registers.
  assign Mem_Addr      = alu_out_reg;
  assign Mem_WData     = store_data;
  assign RegWrite_Addr = dst_reg;
  assign RegWrite_Data = (op_reg == OP_LOAD) ? mdr : alu_out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      alu_out_reg       <= '0;
      mdr               <= '0;
      store_data        <= '0;
      dst_reg           <= '0;
      op_reg            <= '0;
      zero_reg          <= 1'b0;
      pc_write_reg      <= 1'b0;
      pc_write_cond_reg <= 1'b0;
      PC_Out            <= '0;
      Mem_Req           <= 1'b0;
      Mem_We            <= 1'b0;
      RegWrite_En       <= 1'b0;
      Busy              <= 1'b0;
      Done              <= 1'b0;
    end else begin
      RegWrite_En <= 1'b0;
      Done        <= 1'b0;
      case (state)
        IDLE: begin
          if (C_Start) begin
            alu_out_reg       <= ALU_Out;
            zero_reg          <= ALU_Zero;
            op_reg            <= C_Op;
            dst_reg           <= C_RegDst;
            store_data        <= C_StoreData;
            pc_write_reg      <= C_PCWrite;
            pc_write_cond_reg <= C_PCWriteCond;
            Busy              <= 1'b1;
            case (C_Op)
              OP_ALU: begin
                state       <= WB;
                RegWrite_En <= (C_RegDst != '0);
                Done        <= 1'b1;
              end
              OP_LOAD, OP_STORE: begin
                state   <= MEM;
                Mem_Req <= 1'b1;
                Mem_We  <= (C_Op == OP_STORE);
              end
              default: begin
                state <= PCUPD;
                Done  <= 1'b1;
              end
            endcase
          end
        end
        MEM: begin
          if (Mem_Ready) begin
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            Done    <= 1'b1;
            if (op_reg == OP_LOAD) begin
              mdr         <= Mem_RData;
              state       <= WB;
              RegWrite_En <= (dst_reg != '0);
            end else begin
              state <= FIN;
            end
          end
        end
        PCUPD: begin
          // Unconditional load dominates; the conditional one needs the latched zero flag.
          if (pc_write_reg || (pc_write_cond_reg && zero_reg))
            PC_Out <= alu_out_reg;
          state <= IDLE;
          Busy  <= 1'b0;
        end
        WB, FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: directed scenarios plus randomized instructions
// compared against an instruction-level reference model.
module tb_alu_result_writeback;

  logic        clk, rst;
  logic [15:0] ALU_Out, C_StoreData, Mem_RData;
  logic        ALU_Zero, C_Start, C_PCWrite, C_PCWriteCond, Mem_Ready;
  logic [1:0]  C_Op;
  logic [3:0]  C_RegDst;
  logic        Mem_Req, Mem_We, RegWrite_En, Busy, Done;
  logic [15:0] Mem_Addr, Mem_WData, RegWrite_Data, PC_Out;
  logic [3:0]  RegWrite_Addr;

  int passed = 0;
  int total  = 0;

  // reference model state and expectations
  logic [15:0] model_pc;
  int          exp_len, exp_req, exp_wr_cnt;
  logic        exp_we;
  logic [3:0]  exp_wr_addr;
  logic [15:0] exp_wr_data;

  // observations of the last instruction
  int          obs_len, obs_done_cnt, obs_done_cycle, obs_wr_cnt, obs_req_cnt;
  logic        obs_we, obs_unstable, obs_timeout;
  logic [3:0]  obs_wr_addr;
  logic [15:0] obs_wr_data, obs_addr, obs_wdata;

  alu_result_writeback #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .ALU_Out(ALU_Out), .ALU_Zero(ALU_Zero), .C_Start(C_Start),
    .C_Op(C_Op), .C_RegDst(C_RegDst), .C_StoreData(C_StoreData), .C_PCWrite(C_PCWrite),
    .C_PCWriteCond(C_PCWriteCond), .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .RegWrite_En(RegWrite_En), .RegWrite_Addr(RegWrite_Addr), .RegWrite_Data(RegWrite_Data),
    .PC_Out(PC_Out), .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: latency, memory request length, register write and PC effect.
  task automatic model(input logic [1:0] op, input logic [15:0] alu, input logic z,
                       input logic [3:0] dst, input logic pcw, input logic pcwc,
                       input int wait_n, input logic [15:0] rdata);
    bit is_mem;
    is_mem      = (op == 2'b01) || (op == 2'b10);
    exp_len     = is_mem ? wait_n + 2 : 1;
    exp_req     = is_mem ? wait_n + 1 : 0;
    exp_we      = (op == 2'b10);
    exp_wr_cnt  = ((op == 2'b00 || op == 2'b01) && dst != 4'd0) ? 1 : 0;
    exp_wr_addr = dst;
    exp_wr_data = (op == 2'b01) ? rdata : alu;
    if (op == 2'b11 && (pcw || (pcwc && z))) model_pc = alu;
  endtask

  // Issue one instruction, serve memory after wait_n stalled request cycles, and record
  // what the DUT did until it returns to idle (bounded at 12 cycles).
  task automatic run_instr(input logic [1:0] op, input logic [15:0] alu, input logic z,
                           input logic [3:0] dst, input logic [15:0] sd, input logic pcw,
                           input logic pcwc, input int wait_n, input logic [15:0] rdata,
                           input bit noise);
    int k;
    ALU_Out = alu; ALU_Zero = z; C_Op = op; C_RegDst = dst; C_StoreData = sd;
    C_PCWrite = pcw; C_PCWriteCond = pcwc; C_Start = 1'b1;
    Mem_Ready = 1'($urandom_range(0, 1)); Mem_RData = 16'($urandom);
    step();
    C_Start = 1'b0;
    obs_len = 0; obs_done_cnt = 0; obs_done_cycle = 0; obs_wr_cnt = 0; obs_req_cnt = 0;
    obs_we = 1'b0; obs_unstable = 1'b0; obs_wr_addr = '0; obs_wr_data = '0;
    obs_addr = '0; obs_wdata = '0;
    k = 1;
    while (Busy && k <= 12) begin
      obs_len = k;
      if (Done) begin obs_done_cnt++; obs_done_cycle = k; end
      if (RegWrite_En) begin obs_wr_cnt++; obs_wr_addr = RegWrite_Addr; obs_wr_data = RegWrite_Data; end
      if (Mem_Req) begin
        obs_req_cnt++;
        if (obs_req_cnt == 1) begin
          obs_we = Mem_We; obs_addr = Mem_Addr; obs_wdata = Mem_WData;
        end else if (obs_we !== Mem_We || obs_addr !== Mem_Addr || obs_wdata !== Mem_WData) begin
          obs_unstable = 1'b1;
        end
        Mem_Ready = (obs_req_cnt == wait_n + 1);
        Mem_RData = Mem_Ready ? rdata : 16'($urandom);
      end else begin
        Mem_Ready = 1'($urandom_range(0, 1));
        Mem_RData = 16'($urandom);
      end
      if (noise) begin
        C_Start = 1'($urandom_range(0, 1)); ALU_Out = 16'($urandom); ALU_Zero = 1'($urandom_range(0, 1));
        C_Op = 2'($urandom_range(0, 3)); C_RegDst = 4'($urandom_range(0, 15));
        C_StoreData = 16'($urandom); C_PCWrite = 1'($urandom_range(0, 1));
        C_PCWriteCond = 1'($urandom_range(0, 1));
      end
      step();
      k++;
    end
    C_Start = 1'b0;
    obs_timeout = Busy;
    if (obs_timeout) obs_len = 13;
    if (Done) obs_done_cnt++;
    if (RegWrite_En) obs_wr_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if ({Mem_Req, Mem_We, RegWrite_En, Busy, Done} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {Mem_Req, Mem_We, RegWrite_En, Busy, Done}); else passed++;
    total++; if (PC_Out !== 16'h0000) $display("FAIL reset_pc got %h want 0000", PC_Out); else passed++;
    total++; if ({Mem_Addr, Mem_WData, RegWrite_Addr, RegWrite_Data} !== 52'h0)
      $display("FAIL reset_data got %h %h %h %h want zeros", Mem_Addr, Mem_WData, RegWrite_Addr, RegWrite_Data); else passed++;
    rst = 1'b0;
    model_pc = 16'h0000;
    step();
  endtask

  task automatic test_alu_wb();
    run_instr(2'b00, 16'h1234, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    total++; if (obs_done_cycle !== 1 || obs_done_cnt !== 1)
      $display("FAIL alu_done got cycle %0d count %0d want cycle 1 count 1", obs_done_cycle, obs_done_cnt); else passed++;
    total++; if (obs_wr_cnt !== 1 || obs_wr_addr !== 4'd5 || obs_wr_data !== 16'h1234)
      $display("FAIL alu_write got n=%0d R%0d=%h want n=1 R5=1234", obs_wr_cnt, obs_wr_addr, obs_wr_data); else passed++;
    total++; if (obs_len !== 1) $display("FAIL alu_busy_len got %0d want 1", obs_len); else passed++;
  endtask

  task automatic test_back_to_back();
    run_instr(2'b00, 16'h1111, 1'b0, 4'd7, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    run_instr(2'b00, 16'h2222, 1'b0, 4'd8, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    total++; if (obs_wr_cnt !== 1 || obs_wr_addr !== 4'd8 || obs_wr_data !== 16'h2222 || obs_done_cycle !== 1)
      $display("FAIL b2b_second got n=%0d R%0d=%h done@%0d want n=1 R8=2222 done@1",
               obs_wr_cnt, obs_wr_addr, obs_wr_data, obs_done_cycle); else passed++;
  endtask

  task automatic test_load_busy_ignore();
    run_instr(2'b01, 16'h0040, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 3, 16'hBEEF, 1'b1);
    total++; if (obs_req_cnt !== 4 || obs_we !== 1'b0 || obs_addr !== 16'h0040 || obs_unstable !== 1'b0)
      $display("FAIL load_req got n=%0d we=%b addr=%h unstable=%b want n=4 we=0 addr=0040 unstable=0",
               obs_req_cnt, obs_we, obs_addr, obs_unstable); else passed++;
    total++; if (obs_wr_cnt !== 1 || obs_wr_addr !== 4'd3 || obs_wr_data !== 16'hBEEF)
      $display("FAIL load_write got n=%0d R%0d=%h want n=1 R3=beef", obs_wr_cnt, obs_wr_addr, obs_wr_data); else passed++;
    total++; if (obs_done_cycle !== 5 || obs_done_cnt !== 1 || obs_len !== 5)
      $display("FAIL load_done got cycle %0d count %0d len %0d want 5 1 5", obs_done_cycle, obs_done_cnt, obs_len); else passed++;
  endtask

  task automatic test_store();
    run_instr(2'b10, 16'h0080, 1'b0, 4'd9, 16'hA5A5, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    total++; if (obs_req_cnt !== 1 || obs_we !== 1'b1 || obs_addr !== 16'h0080 || obs_wdata !== 16'hA5A5)
      $display("FAIL store_req got n=%0d we=%b addr=%h wdata=%h want n=1 we=1 addr=0080 wdata=a5a5",
               obs_req_cnt, obs_we, obs_addr, obs_wdata); else passed++;
    total++; if (obs_wr_cnt !== 0) $display("FAIL store_nowrite got %0d writes want 0", obs_wr_cnt); else passed++;
    total++; if (obs_done_cycle !== 2 || obs_done_cnt !== 1)
      $display("FAIL store_done got cycle %0d count %0d want 2 1", obs_done_cycle, obs_done_cnt); else passed++;
  endtask

  task automatic test_pc_update();
    run_instr(2'b11, 16'h0100, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    total++; if (PC_Out !== 16'h0000) $display("FAIL pc_cond_nz got %h want 0000", PC_Out); else passed++;
    total++; if (obs_done_cycle !== 1 || obs_wr_cnt !== 0)
      $display("FAIL pc_done got cycle %0d writes %0d want 1 0", obs_done_cycle, obs_wr_cnt); else passed++;
    run_instr(2'b11, 16'h0100, 1'b1, 4'd0, 16'h0, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    total++; if (PC_Out !== 16'h0100) $display("FAIL pc_cond_z got %h want 0100", PC_Out); else passed++;
    run_instr(2'b11, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b0);
    total++; if (PC_Out !== 16'h0002) $display("FAIL pc_uncond got %h want 0002", PC_Out); else passed++;
    run_instr(2'b11, 16'h0ABC, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 0, 16'h0, 1'b0);
    total++; if (PC_Out !== 16'h0ABC) $display("FAIL pc_both got %h want 0abc", PC_Out); else passed++;
    model_pc = 16'h0ABC;
  endtask

  task automatic test_r0();
    run_instr(2'b00, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    total++; if (obs_wr_cnt !== 0 || obs_done_cnt !== 1 || obs_done_cycle !== 1)
      $display("FAIL r0_write got writes %0d done %0d@%0d want 0 1@1", obs_wr_cnt, obs_done_cnt, obs_done_cycle); else passed++;
  endtask

  task automatic test_reset_mid();
    ALU_Out = 16'h0040; C_Op = 2'b01; C_RegDst = 4'd3; C_Start = 1'b1; Mem_Ready = 1'b0;
    step();
    C_Start = 1'b0;
    step();
    total++; if (Mem_Req !== 1'b1) $display("FAIL midrst_pre_req got %b want 1", Mem_Req); else passed++;
    rst = 1'b1;
    step();
    total++; if ({Mem_Req, Busy, Done, RegWrite_En} !== 4'b0 || PC_Out !== 16'h0000)
      $display("FAIL midrst_abort got req=%b busy=%b done=%b we=%b pc=%h want all 0",
               Mem_Req, Busy, Done, RegWrite_En, PC_Out); else passed++;
    rst = 1'b0;
    Mem_Ready = 1'b1;
    step();
    total++; if ({Busy, Done, RegWrite_En} !== 3'b0)
      $display("FAIL midrst_after got busy=%b done=%b we=%b want 000", Busy, Done, RegWrite_En); else passed++;
    Mem_Ready = 1'b0;
    model_pc = 16'h0000;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] alu, sd, rdata;
    logic [3:0]  dst;
    logic        z, pcw, pcwc;
    int          wait_n;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3)); alu = 16'($urandom); sd = 16'($urandom); rdata = 16'($urandom);
      dst = 4'($urandom_range(0, 15)); z = 1'($urandom_range(0, 1));
      pcw = 1'($urandom_range(0, 1)); pcwc = 1'($urandom_range(0, 1)); wait_n = $urandom_range(0, 3);
      model(op, alu, z, dst, pcw, pcwc, wait_n, rdata);
      run_instr(op, alu, z, dst, sd, pcw, pcwc, wait_n, rdata, 1'b1);
      total++; if (obs_len !== exp_len || obs_done_cnt !== 1 || obs_done_cycle !== exp_len)
        $display("FAIL rand_timing[%0d] op=%0d got len %0d done %0d@%0d want len %0d done 1@%0d",
                 i, op, obs_len, obs_done_cnt, obs_done_cycle, exp_len, exp_len); else passed++;
      total++; if (obs_req_cnt !== exp_req) $display("FAIL rand_req[%0d] got %0d want %0d", i, obs_req_cnt, exp_req); else passed++;
      if (exp_req > 0) begin
        total++; if (obs_we !== exp_we || obs_addr !== alu || obs_wdata !== sd || obs_unstable !== 1'b0)
          $display("FAIL rand_mem[%0d] got we=%b addr=%h wdata=%h unstable=%b want we=%b addr=%h wdata=%h unstable=0",
                   i, obs_we, obs_addr, obs_wdata, obs_unstable, exp_we, alu, sd); else passed++;
      end
      total++; if (obs_wr_cnt !== exp_wr_cnt) $display("FAIL rand_wrcnt[%0d] got %0d want %0d", i, obs_wr_cnt, exp_wr_cnt); else passed++;
      if (exp_wr_cnt == 1) begin
        total++; if (obs_wr_addr !== exp_wr_addr || obs_wr_data !== exp_wr_data)
          $display("FAIL rand_wr[%0d] got R%0d=%h want R%0d=%h", i, obs_wr_addr, obs_wr_data, exp_wr_addr, exp_wr_data); else passed++;
      end
      total++; if (PC_Out !== model_pc) $display("FAIL rand_pc[%0d] got %h want %h", i, PC_Out, model_pc); else passed++;
      if (obs_timeout) begin
        $display("FAIL rand_timeout[%0d] DUT stuck busy", i);
        rst = 1'b1; step(); rst = 1'b0; model_pc = 16'h0000;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ALU_Out = '0; ALU_Zero = 1'b0; C_Start = 1'b0; C_Op = '0; C_RegDst = '0;
    C_StoreData = '0; C_PCWrite = 1'b0; C_PCWriteCond = 1'b0; Mem_Ready = 1'b0; Mem_RData = '0;
    model_pc = '0;
    test_reset();
    test_alu_wb();
    test_back_to_back();
    test_load_busy_ignore();
    test_store();
    test_pc_update();
    test_r0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
